// File: rtl/vme_pkg.sv
// Shared definitions for the VME interrupt-acknowledge sequencer.
// State encoding, error vector and default timeout.
package vme_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SETUP   = 3'd2,
        S_STROBE  = 3'd3,
        S_RELEASE = 3'd4,
        S_REPORT  = 3'd5
    } iack_state_t;

    localparam logic [7:0] IACK_ERR_VECTOR = 8'hFF;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int CNT_W = 10;

endpackage

// File: rtl/vme_sync.sv
// Multi-flop synchronizer for active-low asynchronous VME responses.
// Resets to the deasserted (high) level.
module vme_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/vme_iack_sequencer.sv
// VME interrupt-acknowledge cycle sequencer: arbitrates for the bus,
// runs the IACK cycle for the pending level and reports the status/ID.
module vme_iack_sequencer
    import vme_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq,
    input  logic [2:0] vec_addr,
    input  logic [6:0] level_en,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic       vme_iack_n,
    output logic       vme_as_n,
    output logic       vme_ds0_n,
    output logic [2:0] vme_addr,
    input  logic       vme_dtack_n,
    input  logic       vme_berr_n,
    input  logic [7:0] vme_data,
    output logic       iack,
    output logic       dtack,
    output logic       vec_valid,
    output logic [7:0] vec_id,
    output logic [2:0] vec_level,
    output logic       vec_err,
    input  logic       vec_ack
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    iack_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       vec_id_q, vec_id_d;
    logic             vec_err_q, vec_err_d;
    logic             dtack_q, dtack_d;
    logic             dtack_s, berr_s;

    vme_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (vme_dtack_n),
        .q_o     (dtack_s)
    );

    vme_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (vme_berr_n),
        .q_o     (berr_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 3'b000;
            vec_id_q  <= 8'h00;
            vec_err_q <= 1'b0;
            dtack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            vec_id_q  <= vec_id_d;
            vec_err_q <= vec_err_d;
            dtack_q   <= dtack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        vec_id_d  = vec_id_q;
        vec_err_d = vec_err_q;
        dtack_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (irq && vec_addr != 3'd0 && level_en[vec_addr - 3'd1]) begin
                    level_d = vec_addr;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_grant) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                cnt_d = cnt_q + 1'b1;
                // BERR wins over DTACK, DTACK wins over timeout
                if (!berr_s) begin
                    vec_id_d  = IACK_ERR_VECTOR;
                    vec_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else if (!dtack_s) begin
                    vec_id_d  = vme_data;
                    vec_err_d = 1'b0;
                    dtack_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else if (cnt_q == TMO_LAST) begin
                    vec_id_d  = IACK_ERR_VECTOR;
                    vec_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if ((dtack_s && berr_s) || cnt_q == TMO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (vec_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic in_cycle;

    always_comb begin
        in_cycle   = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                     (state_q == S_RELEASE);
        bus_req    = in_cycle || (state_q == S_REQ);
        vme_iack_n = !in_cycle;
        vme_as_n   = (state_q != S_STROBE);
        vme_ds0_n  = (state_q != S_STROBE);
        vme_addr   = in_cycle ? level_q : 3'b000;
        iack       = (state_q == S_RELEASE);
        dtack      = dtack_q;
        vec_valid  = (state_q == S_REPORT);
        vec_id     = vec_id_q;
        vec_level  = level_q;
        vec_err    = vec_err_q;
    end

endmodule

// File: tb/tb_vme_iack_sequencer.sv
// Directed self-checking bench for vme_iack_sequencer.
// Runs with TIMEOUT_CYCLES=16, SYNC_STAGES=2.
module tb_vme_iack_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       irq;
    logic [2:0] vec_addr;
    logic [6:0] level_en;
    logic       bus_req;
    logic       bus_grant;
    logic       vme_iack_n, vme_as_n, vme_ds0_n;
    logic [2:0] vme_addr;
    logic       vme_dtack_n, vme_berr_n;
    logic [7:0] vme_data;
    logic       iack, dtack, vec_valid;
    logic [7:0] vec_id;
    logic [2:0] vec_level;
    logic       vec_err;
    logic       vec_ack;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vme_iack_sequencer #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .vec_addr    (vec_addr),
        .level_en    (level_en),
        .bus_req     (bus_req),
        .bus_grant   (bus_grant),
        .vme_iack_n  (vme_iack_n),
        .vme_as_n    (vme_as_n),
        .vme_ds0_n   (vme_ds0_n),
        .vme_addr    (vme_addr),
        .vme_dtack_n (vme_dtack_n),
        .vme_berr_n  (vme_berr_n),
        .vme_data    (vme_data),
        .iack        (iack),
        .dtack       (dtack),
        .vec_valid   (vec_valid),
        .vec_id      (vec_id),
        .vec_level   (vec_level),
        .vec_err     (vec_err),
        .vec_ack     (vec_ack)
    );

    task automatic wait_as_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vme_as_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok, output int pulses);
        ok = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dtack === 1'b1) pulses++;
            if (iack === 1'b1) begin
                vme_dtack_n = 1'b1;
                vme_berr_n  = 1'b1;
            end
            if (vec_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_to_report(input logic [2:0] lvl, input logic [7:0] data,
                                 output bit ok);
        bit ok1, ok2;
        int p;
        irq = 1'b1;
        vec_addr = lvl;
        bus_grant = 1'b1;
        wait_as_low(ok1);
        irq = 1'b0;
        vme_dtack_n = 1'b0;
        vme_data = data;
        wait_valid(ok2, p);
        ok = ok1 && ok2 && (p == 1);
    endtask

    task automatic do_ack();
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        irq = 1'b0;
        vec_addr = 3'd0;
        level_en = 7'h7F;
        bus_grant = 1'b0;
        vme_dtack_n = 1'b1;
        vme_berr_n = 1'b1;
        vme_data = 8'h00;
        vec_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({vme_iack_n, vme_as_n, vme_ds0_n} !== 3'b111) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 111",
                     {vme_iack_n, vme_as_n, vme_ds0_n});
        end
        total++;
        if ({bus_req, iack, dtack, vec_valid, vec_err} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus_req, iack, dtack, vec_valid, vec_err});
        end
        total++;
        if ({vme_addr, vec_level, vec_id} !== 14'h0) begin
            bad++;
            $display("FAIL reset_vals: got %h/%h/%h want 0/0/00",
                     vme_addr, vec_level, vec_id);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        bit ok;
        int p, n;
        irq = 1'b1;
        vec_addr = 3'd5;
        level_en = 7'h7F;
        bus_grant = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({bus_req, vme_iack_n, vme_as_n} !== 3'b111) begin
                bad++;
                $display("FAIL req_wait: got %b want 111",
                         {bus_req, vme_iack_n, vme_as_n});
            end
        end
        bus_grant = 1'b1;
        irq = 1'b0;
        @(negedge clk);
        total++;
        if ({vme_addr, vme_iack_n, vme_as_n, vme_ds0_n} !== {3'd5, 3'b011}) begin
            bad++;
            $display("FAIL setup: got %b want 101011",
                     {vme_addr, vme_iack_n, vme_as_n, vme_ds0_n});
        end
        @(negedge clk);
        total++;
        if ({vme_addr, vme_iack_n, vme_as_n, vme_ds0_n} !== {3'd5, 3'b000}) begin
            bad++;
            $display("FAIL strobe: got %b want 101000",
                     {vme_addr, vme_iack_n, vme_as_n, vme_ds0_n});
        end
        bus_grant = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (vme_as_n !== 1'b0) begin
            bad++;
            $display("FAIL strobe_hold: got as_n=%b want 0", vme_as_n);
        end
        vme_dtack_n = 1'b0;
        vme_data = 8'h42;
        n = 0;
        wait_valid(ok, p);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL normal_valid: got timeout want vec_valid");
        end
        total++;
        if (p !== 1) begin
            bad++;
            $display("FAIL normal_dtack_pulses: got %0d want 1", p);
        end
        total++;
        if ({vec_id, vec_level, vec_err} !== {8'h42, 3'd5, 1'b0}) begin
            bad++;
            $display("FAIL normal_vec: got %h/%0d/%b want 42/5/0",
                     vec_id, vec_level, vec_err);
        end
        total++;
        if ({bus_req, vme_iack_n} !== 2'b01) begin
            bad++;
            $display("FAIL report_bus: got %b want 01", {bus_req, vme_iack_n});
        end
        bus_grant = 1'b1;
        do_ack();
        total++;
        if (vec_valid !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear: got %b want 0", vec_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n, p;
        irq = 1'b1;
        vec_addr = 3'd2;
        bus_grant = 1'b1;
        wait_as_low(ok);
        irq = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && vme_as_n === 1'b0; i++) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL timeout_len: got %0d want 16", n);
        end
        total++;
        if ({iack, vme_ds0_n} !== 2'b11) begin
            bad++;
            $display("FAIL timeout_release: got %b want 11", {iack, vme_ds0_n});
        end
        wait_valid(ok, p);
        total++;
        if (!ok || {vec_err, vec_id, vec_level, p[0]} !== {1'b1, 8'hFF, 3'd2, 1'b0}) begin
            bad++;
            $display("FAIL timeout_vec: got ok=%b err=%b id=%h lvl=%0d p=%0d want 1/1/ff/2/0",
                     ok, vec_err, vec_id, vec_level, p);
        end
        do_ack();
    endtask

    task automatic test_berr_dtack();
        bit ok;
        int p;
        irq = 1'b1;
        vec_addr = 3'd7;
        wait_as_low(ok);
        irq = 1'b0;
        vme_dtack_n = 1'b0;
        vme_berr_n = 1'b0;
        vme_data = 8'h55;
        wait_valid(ok, p);
        total++;
        if (!ok || p !== 0) begin
            bad++;
            $display("FAIL berr_pulse: got ok=%b pulses=%0d want 1/0", ok, p);
        end
        total++;
        if ({vec_err, vec_id, vec_level} !== {1'b1, 8'hFF, 3'd7}) begin
            bad++;
            $display("FAIL berr_vec: got %b/%h/%0d want 1/ff/7",
                     vec_err, vec_id, vec_level);
        end
        do_ack();
    endtask

    task automatic test_masked();
        int hits;
        level_en = 7'b1111011;
        irq = 1'b1;
        vec_addr = 3'd3;
        hits = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_req !== 1'b0 || vme_iack_n !== 1'b1) hits++;
        end
        total++;
        if (hits !== 0) begin
            bad++;
            $display("FAIL masked_idle: got %0d active cycles want 0", hits);
        end
        level_en = 7'h00;
        repeat (10) @(negedge clk);
        total++;
        if (bus_req !== 1'b0) begin
            bad++;
            $display("FAIL masked_all: got bus_req=%b want 0", bus_req);
        end
        irq = 1'b0;
        level_en = 7'h7F;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hits;
        irq = 1'b1;
        vec_addr = 3'd1;
        wait_as_low(ok);
        irq = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if (!ok || {vme_as_n, vme_ds0_n, vme_iack_n, bus_req, vec_valid} !== 5'b11100) begin
            bad++;
            $display("FAIL midreset_strobes: got ok=%b %b want 1 11100", ok,
                     {vme_as_n, vme_ds0_n, vme_iack_n, bus_req, vec_valid});
        end
        @(negedge clk);
        reset_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (vec_valid !== 1'b0 || bus_req !== 1'b0) hits++;
        end
        total++;
        if (hits !== 0) begin
            bad++;
            $display("FAIL midreset_novec: got %0d bad cycles want 0", hits);
        end
        run_to_report(3'd4, 8'hA5, ok);
        total++;
        if (!ok || {vec_id, vec_level, vec_err} !== {8'hA5, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL midreset_rerun: got ok=%b %h/%0d/%b want 1 a5/4/0",
                     ok, vec_id, vec_level, vec_err);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int hits;
        run_to_report(3'd6, 8'h3C, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_setup: got timeout want report");
        end
        irq = 1'b1;
        vec_addr = 3'd1;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if ({vec_valid, vec_id, vec_level, vec_err, bus_req} !==
                {1'b1, 8'h3C, 3'd6, 1'b0, 1'b0}) hits++;
        end
        total++;
        if (hits !== 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d changed cycles want 0", hits);
        end
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        total++;
        if ({vec_valid, bus_req} !== 2'b00) begin
            bad++;
            $display("FAIL idle_gap: got %b want 00", {vec_valid, bus_req});
        end
        @(negedge clk);
        total++;
        if ({bus_req, vme_iack_n} !== 2'b11) begin
            bad++;
            $display("FAIL next_req: got %b want 11", {bus_req, vme_iack_n});
        end
        irq = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_berr_dtack();
        test_masked();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
